rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_arbiter_8_if.sv | 25 ++
 rtl/arb_enc_8_3.sv | 20 ++
 rtl/rr_arbiter_8.sv | 119 +++++++++++
 tb/tb_rr_arbiter_8.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing constants for the 8-way round-robin arbiter.
// Holds the FSM state type (IDLE/BUSY), requester count, grant index width
// and the timeout counter width.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// Signals:
//   en     : arbitration enable, 1 = new grants allowed
//   req    : request vector, bit i = requester i
//   done   : current owner releases the resource
//   gnt    : registered one-hot grant, zero when no owner
//   gnt_id : binary index of the set gnt bit, 0 when gnt = 0
//   valid  : high exactly when gnt != 0
//   to     : one-cycle pulse on a forced timeout release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             valid;
  logic             to;

  modport master (output en, req, done, input gnt, gnt_id, valid, to);
  modport slave  (input en, req, done, output gnt, gnt_id, valid, to);

endinterface

// File: rtl/arb_enc_8_3.sv
// Combinational one-hot to binary encoder for the grant vector.
// Ports:
//   onehot : 8-bit one-hot (or zero) input
//   idx    : 3-bit index of the set bit, 0 on all-zero input
module arb_enc_8_3
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx
);

  // OR-reduce the indices of set bits; exact for one-hot inputs.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | ID_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a held grant released by done.
// Optional forced release after TIMEOUT_CYCLES busy cycles, compiled in
// only when macro ARB_TIMEOUT_EN is defined; otherwise to is tied to 0.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_8_if.slave (en, req, done in; gnt, gnt_id, valid, to out)
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arbiter_8: TIMEOUT_CYCLES out of range 2..255");
  end

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt, gnt_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [ID_W-1:0]  gnt_id;
  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  scan_idx;
  logic             found;
  logic             expired_c;

  // Rotating priority search starting at ptr.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = ptr + ID_W'(i);
      if (!found && bus.req[scan_idx]) begin
        pick[scan_idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             to_q;

  // cnt holds the number of completed busy cycles minus one at the edge
  // that closes busy cycle TIMEOUT_CYCLES.
  assign expired_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Busy-cycle counter, cleared in IDLE so it starts at 0 on BUSY entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      cnt  <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
      // done on the same edge wins, so no pulse.
      to_q <= (state == BUSY) && expired_c && !bus.done;
    end
  end

  assign bus.to = to_q;
`else
  assign expired_c = 1'b0;
  assign bus.to    = 1'b0;
`endif

  // Next-state and next-grant logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (bus.en && (|bus.req)) begin
          gnt_nxt   = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.done || expired_c) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
          ptr_nxt   = gnt_id + ID_W'(1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  arb_enc_8_3 u_enc (
    .onehot (gnt),
    .idx    (gnt_id)
  );

  assign bus.gnt    = gnt;
  assign bus.gnt_id = gnt_id;
  assign bus.valid  = |gnt;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus a random
// phase scored against a small reference model. Build with ARB_TIMEOUT_EN
// defined to also cover the forced-release path (TIMEOUT_CYCLES = 4).
module tb_rr_arbiter_8;

  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [7:0] gnt;
    logic       to;
  } exp_t;

  logic clk;
  logic rst_n;
  logic mon_on;
  int unsigned n_chk;
  int unsigned n_pass;
  exp_t exp_q[$];

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [2:0] id_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, score after the edge.
  task automatic cyc(input string tag, input logic e, input logic [7:0] r, input logic d,
                     input logic [7:0] eg, input logic et);
    exp_t x;
    bus.en   = e;
    bus.req  = r;
    bus.done = d;
    exp_q.push_back('{gnt: eg, to: et});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check({tag, ".gnt"},    32'(bus.gnt),    32'(x.gnt));
      check({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(id_of(x.gnt)));
      check({tag, ".valid"},  32'(bus.valid),  32'(|x.gnt));
      check({tag, ".to"},     32'(bus.to),     32'(x.to));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".gnt"},    32'(bus.gnt),    32'd0);
    check({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'd0);
    check({tag, ".valid"},  32'(bus.valid),  32'd0);
    check({tag, ".to"},     32'(bus.to),     32'd0);
  endtask

  // Every-cycle invariants: grant one-hot-or-zero, valid tracks grant.
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      check("inv.onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("inv.valid",   32'(bus.valid), 32'(bus.gnt != 8'h00));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       e, d, m_busy, m_to;
    logic [7:0] r, m_gnt;
    logic [2:0] m_ptr, m_idx, idx;
    int unsigned m_cnt;

    n_chk  = 0;
    n_pass = 0;
    mon_on = 1'b1;
    rst_n  = 1'b0;
    bus.en = 1'b0; bus.req = 8'h00; bus.done = 1'b0;
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Basic grant, release, round-robin advance.
    cyc("r30a", 1'b1, 8'h14, 1'b0, 8'h04, 1'b0);
    cyc("r30b", 1'b1, 8'h14, 1'b1, 8'h00, 1'b0);
    cyc("r30c", 1'b1, 8'h14, 1'b0, 8'h10, 1'b0);
    cyc("r30d", 1'b1, 8'h14, 1'b1, 8'h00, 1'b0);

    // Serve requester 6 to put the pointer at 7, then wrap.
    cyc("r31a", 1'b1, 8'h40, 1'b0, 8'h40, 1'b0);
    cyc("r31b", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc("r31c", 1'b1, 8'h81, 1'b0, 8'h80, 1'b0);
    cyc("r31d", 1'b1, 8'h81, 1'b1, 8'h00, 1'b0);
    cyc("r31e", 1'b1, 8'h81, 1'b0, 8'h01, 1'b0);
    cyc("r31f", 1'b1, 8'h81, 1'b1, 8'h00, 1'b0);

    // Grant held through request drop and EN=0; no regrant while disabled.
    cyc("r32a", 1'b1, 8'h02, 1'b0, 8'h02, 1'b0);
    cyc("r32b", 1'b0, 8'h20, 1'b0, 8'h02, 1'b0);
    cyc("r32c", 1'b0, 8'h20, 1'b0, 8'h02, 1'b0);
    cyc("r32d", 1'b0, 8'h20, 1'b1, 8'h00, 1'b0);
    cyc("r32e", 1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    cyc("r32f", 1'b0, 8'h20, 1'b1, 8'h00, 1'b0);
    cyc("r32g", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    // DONE in IDLE must not move the pointer (still 2).
    cyc("r32h", 1'b1, 8'hFF, 1'b0, 8'h04, 1'b0);
    cyc("r32i", 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset mid-cycle while busy.
    cyc("r33a", 1'b1, 8'h08, 1'b0, 8'h08, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("r33.async");
    @(posedge clk);
    #1 check_idle_outputs("r33.held");
    #3 rst_n = 1'b1;
    cyc("r33b", 1'b1, 8'hFF, 1'b0, 8'h01, 1'b0);
    cyc("r33c", 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Forced release after TMO busy cycles, one-cycle TO pulse.
    cyc("r34a", 1'b1, 8'h04, 1'b0, 8'h04, 1'b0);
    for (int k = 1; k < TMO; k++) cyc("r34hold", 1'b1, 8'h00, 1'b0, 8'h04, 1'b0);
    cyc("r34to",  1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc("r34end", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    // DONE on the timeout cycle takes priority.
    cyc("r34b", 1'b1, 8'h08, 1'b0, 8'h08, 1'b0);
    for (int k = 1; k < TMO; k++) cyc("r34bhold", 1'b1, 8'h00, 1'b0, 8'h08, 1'b0);
    cyc("r34bdone", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    cyc("r34bend",  1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
`else
    // Without the timeout feature the grant is held indefinitely.
    cyc("hold_a", 1'b1, 8'h04, 1'b0, 8'h04, 1'b0);
    for (int k = 0; k < 20; k++) cyc("hold", 1'b1, 8'h00, 1'b0, 8'h04, 1'b0);
    cyc("hold_rel", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
`endif

    // Random phase from a fresh reset against a reference model.
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_busy = 1'b0; m_ptr = '0; m_gnt = '0; m_idx = '0; m_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      e = ($urandom_range(0, 3) != 0);
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      d = ($urandom_range(0, 2) == 0);
      m_to = 1'b0;
      if (!m_busy) begin
        if (e && r != 8'h00) begin
          for (int i = 0; i < 8; i++) begin
            idx = 3'(m_ptr + 3'(i));
            if (r[idx] && !m_busy) begin
              m_gnt  = 8'(1) << idx;
              m_idx  = idx;
              m_busy = 1'b1;
              m_cnt  = 0;
            end
          end
        end
      end else if (d) begin
        m_gnt  = 8'h00;
        m_busy = 1'b0;
        m_ptr  = 3'(m_idx + 3'd1);
      end else begin
        m_cnt++;
`ifdef ARB_TIMEOUT_EN
        if (m_cnt == TMO) begin
          m_gnt  = 8'h00;
          m_busy = 1'b0;
          m_ptr  = 3'(m_idx + 3'd1);
          m_to   = 1'b1;
        end
`endif
      end
      cyc("rnd", e, r, d, m_gnt, m_to);
    end

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
